// File: rtl/local_buffer_dp.sv
// local_buffer_dp: simple-dual-port scratch buffer, byte-enable writes, write-first forwarding, 2-deep read response queue.
// Optional per-byte even parity with macro LOCAL_BUF_PARITY_EN.
module local_buffer_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  rd_rsp_err,
  output logic [1:0]            credits
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, s1_data;
  logic [DATA_WIDTH-1:0] q_data [2];
  logic [1:0] q_err;
  logic [1:0] count;
  logic [BE_WIDTH-1:0] fwd;
  logic rd_perr, s1_err, s1_valid, wr_ptr, rd_ptr, accept, pop;

  assign fwd = {BE_WIDTH{wr_valid && (wr_addr == rd_addr)}} & wr_be;
  assign rd_rsp_valid = count != 2'd0;
  assign pop = rd_rsp_valid & rd_rsp_ready;
  assign credits = count + {1'b0, s1_valid};
  // credits never exceeds 2, so the queue cannot overflow
  assign rd_req_ready = ~credits[1] | pop;
  assign accept = rd_req_valid & rd_req_ready;
  assign rd_rsp_data = rd_rsp_valid ? q_data[rd_ptr] : '0;
  assign rd_rsp_err = rd_rsp_valid & q_err[rd_ptr];

  always_ff @(posedge clk)
    for (int i = 0; i < BE_WIDTH; i++)
      if (wr_valid && wr_be[i]) mem[wr_addr][8*i+:8] <= wr_data[8*i+:8];

  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < BE_WIDTH; i++)
      if (fwd[i]) rd_word[8*i+:8] = wr_data[8*i+:8];
  end

`ifdef LOCAL_BUF_PARITY_EN
  logic [BE_WIDTH-1:0] par [DEPTH];

  always_ff @(posedge clk)
    for (int i = 0; i < BE_WIDTH; i++)
      if (wr_valid && wr_be[i]) par[wr_addr][i] <= ^wr_data[8*i+:8];

  // forwarded bytes carry fresh parity and can never mismatch
  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < BE_WIDTH; i++)
      if (!fwd[i] && ((^mem[rd_addr][8*i+:8]) != par[rd_addr][i])) rd_perr = 1'b1;
  end
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_err <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= rd_word;
        s1_err <= rd_perr;
      end
      if (s1_valid) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, s1_valid} - {1'b0, pop};
    end

  always_ff @(posedge clk)
    if (s1_valid) begin
      q_data[wr_ptr] <= s1_data;
      q_err[wr_ptr] <= s1_err;
    end
endmodule

// File: tb/tb_local_buffer_dp.sv
// tb_local_buffer_dp: scoreboard bench for local_buffer_dp with a word-array reference model.
module tb_local_buffer_dp;
  localparam int DW = 32, DEPTH = 16, AW = 4, BW = 4;
  typedef struct {logic [DW-1:0] data; logic err; int t;} exp_t;

  logic clk = 1'b0, rst_n = 1'b1;
  logic wr_valid = 1'b0, rd_req_valid = 1'b0, rd_rsp_ready = 1'b1;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [BW-1:0] wr_be = '0;
  logic rd_req_ready, rd_rsp_valid, rd_rsp_err;
  logic [DW-1:0] rd_rsp_data;
  logic [1:0] credits;

  exp_t sb [$];
  logic [DW-1:0] mm [DEPTH];
  logic [BW-1:0] bad [DEPTH];
  int checks = 0, failures = 0, edge_n = 0;

  local_buffer_dp #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_err(rd_rsp_err), .credits(credits)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: expected outputs derive only from the scoreboard contents
  initial forever begin
    logic ev;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      sb.delete();
      chk("rst_valid", DW'(rd_rsp_valid), 0);
      chk("rst_credits", DW'(credits), 0);
      chk("rst_ready", DW'(rd_req_ready), 1);
      chk("rst_data", rd_rsp_data, 0);
      chk("rst_err", DW'(rd_rsp_err), 0);
    end else begin
      ev = 1'b0;
      if (sb.size() > 0) ev = sb[0].t <= edge_n - 1;
      chk("credits", DW'(credits), DW'(sb.size()));
      chk("rsp_valid", DW'(rd_rsp_valid), DW'(ev));
      chk("req_ready", DW'(rd_req_ready), DW'((sb.size() < 2) || (ev && rd_rsp_ready)));
      if (ev && rd_rsp_valid) begin
        chk("rsp_data", rd_rsp_data, sb[0].data);
        chk("rsp_err", DW'(rd_rsp_err), DW'(sb[0].err));
        if (rd_rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [BW-1:0] wbe, input logic rv, input logic [AW-1:0] ra,
                      input logic rr, output logic acc);
    exp_t e;
    logic [BW-1:0] f;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_req_valid = rv; rd_addr = ra; rd_rsp_ready = rr;
    @(negedge clk);
    #2;
    acc = rv && rd_req_ready;
    f = (wv && wa == ra) ? wbe : '0;
    if (acc) begin
      e.data = mm[ra];
      for (int i = 0; i < BW; i++) if (f[i]) e.data[8*i+:8] = wd[8*i+:8];
`ifdef LOCAL_BUF_PARITY_EN
      e.err = |(bad[ra] & ~f);
`else
      e.err = 1'b0;
`endif
      e.t = edge_n + 1;
      sb.push_back(e);
    end
    if (wv)
      for (int i = 0; i < BW; i++)
        if (wbe[i]) begin
          mm[wa][8*i+:8] = wd[8*i+:8];
          bad[wa][i] = 1'b0;
        end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rr);
    logic acc;
    for (int n = 0; n < 20; n++) begin
      step(0, 0, 0, 0, 1, a, rr, acc);
      if (acc) return;
    end
    $display("FAIL rd_accept: address %0d never accepted", a);
    $fatal(1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; sb.size() != 0; n++) begin
      if (n > 20) begin
        $display("FAIL drain: %0d responses never delivered", sb.size());
        $fatal(1);
      end
      step(0, 0, 0, 0, 0, 0, 1, acc);
    end
  endtask

  initial begin
    logic acc, rv;
    logic [AW-1:0] ra;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      bad[a] = '0;
      step(1, AW'(a), $urandom, 4'hF, 0, 0, 1, acc);
    end
    step(1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 1, acc);
    rd(5, 1);
    step(1, 7, 32'h11223344, 4'hF, 0, 0, 1, acc);
    step(1, 7, 32'hAABBCCDD, 4'h5, 0, 0, 1, acc);
    rd(7, 1);
    drain();
    rd(0, 0);
    rd(1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 2, 0, acc);
    rd(2, 1);
    drain();
    step(1, 9, 32'h0, 4'hF, 0, 0, 1, acc);
    step(1, 9, 32'hFFFF0000, 4'hC, 1, 9, 1, acc);
    if (!acc) begin
      $display("FAIL collision_accept: read not accepted");
      $fatal(1);
    end
    drain();
    rd(5, 0);
    rd(6, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, acc);
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(5, 1);
    drain();
`ifdef LOCAL_BUF_PARITY_EN
    step(1, 3, $urandom, 4'hF, 0, 0, 1, acc);
    dut.par[3][0] = ~dut.par[3][0];
    bad[3][0] = 1'b1;
    rd(3, 1);
    rd(4, 1);
    step(1, 3, $urandom, 4'h1, 0, 0, 1, acc);
    rd(3, 1);
    drain();
`endif
    rv = 1'b0;
    ra = '0;
    repeat (3000) begin
      if (!rv || acc) begin
        rv = 1'($urandom_range(0, 1));
        ra = AW'($urandom_range(0, DEPTH - 1));
      end
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
           BW'($urandom), rv, ra, $urandom_range(0, 3) != 0, acc);
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
